rram_readout_master: RTL and testbench

//  Host-side read initiator for the RRAM data-register readout port. Drives chip enable (ce, active low)
//  and read strobe (re, active low), and walks the data register from address 0 to BURST_LEN-1.

---
 rtl/rram_readout_if.sv | 47 ++++
 rtl/rram_readout_master.sv | 188 ++++++++++++++++++
 tb/tb_rram_readout_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rram_readout_if.sv
`default_nettype none
// ============================================================================
//  Module      : rram_readout_if
//  Description : Host/RRAM readout bundle for rram_readout_master. The master
//                modport is the readout initiator; slave is the host/array side.
//                Optional parity signals are present when RD_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface rram_readout_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] dq_in;
    logic              ce;
    logic              re;
    logic [DATA_W-1:0] rd_data;
    logic [4:0]        rd_add;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;
`ifdef RD_PARITY_EN
    logic              dq_par;
    logic              par_clr;
    logic              par_err;
`endif

    modport master (
        input  start, abort, dq_in, rd_ready,
`ifdef RD_PARITY_EN
        input  dq_par, par_clr,
        output par_err,
`endif
        output ce, re, rd_data, rd_add, rd_valid, busy, done
    );

    modport slave (
        output start, abort, dq_in, rd_ready,
`ifdef RD_PARITY_EN
        output dq_par, par_clr,
        input  par_err,
`endif
        input  ce, re, rd_data, rd_add, rd_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/rram_readout_master.sv
`default_nettype none
// ============================================================================
//  Module      : rram_readout_master
//  Description : Host-side read initiator for the RRAM data-register readout
//                port. Generates ce/re, walks addresses 0..BURST_LEN-1,
//                captures dq_in on each re rising edge and offers every word
//                on a single-entry valid/ready stream.
//                Optional feature macro: RD_PARITY_EN (dq_par check, sticky
//                par_err cleared by par_clr).
//  Revision    : 1.0  initial release
// ============================================================================
module rram_readout_master #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 32,
    parameter int RE_HALF   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    rram_readout_if.master bus
);
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_RE_LO = 3'd2;
    localparam logic [2:0] c_ST_RE_HI = 3'd3;
    localparam logic [2:0] c_ST_STALL = 3'd4;
    localparam logic [2:0] c_ST_HOLD  = 3'd5;

    localparam int                 c_TMR_W    = (RE_HALF > 1) ? $clog2(RE_HALF) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(RE_HALF - 1);
    localparam logic [5:0]         c_CNT_LAST = 6'(BURST_LEN - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [5:0]         r_cnt;
    logic               r_ce;
    logic               r_re;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [4:0]         r_rd_add;

    logic w_phase_end;
    logic w_handshake;
    logic w_slot_free;
    logic w_capture;
    logic w_ce_nxt;
    logic w_re_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_phase_end = (r_tmr == c_TMR_LAST);
    assign w_handshake = r_rd_valid & bus.rd_ready;
    // The output slot is free if empty or being emptied this cycle.
    assign w_slot_free = ~r_rd_valid | bus.rd_ready;
    // A word is taken on the edge that leaves RE_LO normally (not via abort).
    assign w_capture   = (r_state == c_ST_RE_LO) & w_phase_end & ~bus.abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; abort has priority in every active state except HOLD
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A pending word from the previous burst blocks a new start.
                if (bus.start && !r_rd_valid) w_state_nxt = c_ST_SETUP;
            end
            c_ST_SETUP: begin
                w_state_nxt = bus.abort ? c_ST_HOLD : c_ST_RE_LO;
            end
            c_ST_RE_LO: begin
                if (bus.abort)        w_state_nxt = c_ST_HOLD;
                else if (w_phase_end) w_state_nxt = c_ST_RE_HI;
            end
            c_ST_RE_HI: begin
                if (bus.abort)                w_state_nxt = c_ST_HOLD;
                else if (w_phase_end) begin
                    if (r_cnt == c_CNT_LAST)  w_state_nxt = c_ST_HOLD;
                    else if (w_slot_free)     w_state_nxt = c_ST_RE_LO;
                    else                      w_state_nxt = c_ST_STALL;
                end
            end
            c_ST_STALL: begin
                if (bus.abort)        w_state_nxt = c_ST_HOLD;
                else if (w_handshake) w_state_nxt = c_ST_RE_LO;
            end
            c_ST_HOLD: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so that every strobe is a flop output
    always_comb begin
        w_ce_nxt   = 1'b1;
        w_re_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_done_nxt = (r_state == c_ST_HOLD);
        case (w_state_nxt)
            c_ST_SETUP, c_ST_RE_HI, c_ST_STALL: w_ce_nxt = 1'b0;
            c_ST_RE_LO: begin
                w_ce_nxt = 1'b0;
                w_re_nxt = 1'b0;
            end
            default: w_ce_nxt = 1'b1;
        endcase
    end

    // Strobe and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce   <= 1'b1;
            r_re   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ce   <= w_ce_nxt;
            r_re   <= w_re_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Half-period timer and word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_state_nxt != r_state) r_tmr <= '0;
            else if ((r_state == c_ST_RE_LO) || (r_state == c_ST_RE_HI)) r_tmr <= r_tmr + 1'b1;

            if ((r_state == c_ST_IDLE) && (w_state_nxt == c_ST_SETUP)) r_cnt <= '0;
            else if ((r_state == c_ST_RE_HI) && w_phase_end && !bus.abort) r_cnt <= r_cnt + 6'd1;
        end
    end

    // Single-entry output buffer: capture on re rise, release on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_add   <= '0;
        end else if (w_capture) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= bus.dq_in;
            r_rd_add   <= r_cnt[4:0];
        end else if (w_handshake) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bus.ce       = r_ce;
    assign bus.re       = r_re;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_add   = r_rd_add;

`ifdef RD_PARITY_EN
    logic r_par_err;
    logic w_par_bad;

    // Even parity: dq_par must equal the XOR of all data bits.
    assign w_par_bad = w_capture & ((^bus.dq_in) ^ bus.dq_par);

    // Sticky error; a fresh mismatch wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_par_err <= 1'b0;
        else if (w_par_bad)   r_par_err <= 1'b1;
        else if (bus.par_clr) r_par_err <= 1'b0;
    end

    assign bus.par_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rram_readout_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rram_readout_master
//  Description : Directed self-checking bench for rram_readout_master.
//                Instance A: BURST_LEN=32, RE_HALF=1. Instance B: BURST_LEN=4,
//                RE_HALF=3. Parity checks compiled in with RD_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rram_readout_master;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rram_readout_if #(.DATA_W(8)) bus_a ();
    rram_readout_if #(.DATA_W(8)) bus_b ();

    rram_readout_master #(.DATA_W(8), .BURST_LEN(32), .RE_HALF(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    rram_readout_master #(.DATA_W(8), .BURST_LEN(4), .RE_HALF(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Array-side register address: cleared while ce is high, advanced on re rise
    logic [4:0] arr_add_a = 5'd0;
    logic [4:0] arr_add_b = 5'd0;
    always @(posedge bus_a.re or posedge bus_a.ce)
        if (bus_a.ce) arr_add_a <= 5'd0; else arr_add_a <= arr_add_a + 5'd1;
    always @(posedge bus_b.re or posedge bus_b.ce)
        if (bus_b.ce) arr_add_b <= 5'd0; else arr_add_b <= arr_add_b + 5'd1;
    assign bus_a.dq_in = {3'b000, arr_add_a} ^ 8'hA5;
    assign bus_b.dq_in = {3'b000, arr_add_b} ^ 8'hA5;

`ifdef RD_PARITY_EN
    logic par_bad = 1'b0;
    assign bus_a.dq_par = (^bus_a.dq_in) ^ (par_bad && (arr_add_a == 5'd7));
    assign bus_b.dq_par = ^bus_b.dq_in;
`endif

    // Accepted-word log per instance
    logic [4:0] q_add_a[$];
    logic [7:0] q_dat_a[$];
    logic [4:0] q_add_b[$];
    logic [7:0] q_dat_b[$];
    always @(negedge clk) begin
        if (bus_a.rd_valid && bus_a.rd_ready) begin
            q_add_a.push_back(bus_a.rd_add);
            q_dat_a.push_back(bus_a.rd_data);
        end
        if (bus_b.rd_valid && bus_b.rd_ready) begin
            q_add_b.push_back(bus_b.rd_add);
            q_dat_b.push_back(bus_b.rd_data);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel, input logic with_abort);
        if (sel) begin bus_b.start = 1'b1; bus_b.abort = with_abort; end
        else     begin bus_a.start = 1'b1; bus_a.abort = with_abort; end
        tick();
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
    endtask

    // Runs until done (bounded); counts cycles, ce-low and re-low samples, re falls
    task automatic wait_done(input bit sel, output int ncyc, output int nce,
                             output int nlow, output int nfall);
        logic ce_s, re_s, re_prev, dn;
        ncyc = 0; nce = 0; nlow = 0; nfall = 0;
        re_prev = sel ? bus_b.re : bus_a.re;
        if (!(sel ? bus_b.ce : bus_a.ce)) nce++;
        do begin
            tick();
            ncyc++;
            ce_s = sel ? bus_b.ce : bus_a.ce;
            re_s = sel ? bus_b.re : bus_a.re;
            dn   = sel ? bus_b.done : bus_a.done;
            if (!ce_s) nce++;
            if (!re_s) nlow++;
            if (re_prev && !re_s) nfall++;
            re_prev = re_s;
        end while (!dn && ncyc < 2000);
    endtask

    task automatic wait_word_a(input logic [4:0] add);
        for (int i = 0; i < 300; i++) begin
            if (bus_a.rd_valid && bus_a.rd_add == add) break;
            tick();
        end
    endtask

    initial begin
        int ncyc, nce, nlow, nfall, nlo, errs, re_lo_cnt, ce_hi_cnt;
        rst_n = 1'b0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.rd_ready = 1'b1;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.rd_ready = 1'b1;
`ifdef RD_PARITY_EN
        bus_a.par_clr = 1'b0; bus_b.par_clr = 1'b0;
`endif
        tick(); tick();
        check("rst_ce", bus_a.ce, 1);
        check("rst_re", bus_a.re, 1);
        check("rst_rd_data", bus_a.rd_data, 0);
        check("rst_rd_add", bus_a.rd_add, 0);
        check("rst_rd_valid", bus_a.rd_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // T1: full burst, start together with abort in IDLE (start wins)
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b1);
        check("t1_busy", bus_a.busy, 1);
        wait_done(1'b0, ncyc, nce, nlow, nfall);
        check("t1_cycles", ncyc, 66);
        check("t1_ce_low", nce, 65);
        check("t1_done", bus_a.done, 1);
        tick();
        check("t1_done_pulse", bus_a.done, 0);
        check("t1_busy_end", bus_a.busy, 0);
        check("t1_ce_end", bus_a.ce, 1);
        check("t1_words", q_add_a.size(), 32);
        for (int i = 0; i < q_add_a.size(); i++) begin
            check($sformatf("t1_add%0d", i), q_add_a[i], i);
            check($sformatf("t1_data%0d", i), q_dat_a[i], i ^ 8'hA5);
        end

        // T2: back-pressure after word 3
        tick();
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b0);
        wait_word_a(5'd3);
        bus_a.rd_ready = 1'b0;
        re_lo_cnt = 0; ce_hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!bus_a.re) re_lo_cnt++;
            if (bus_a.ce) ce_hi_cnt++;
        end
        check("t2_re_low_in_stall", re_lo_cnt, 0);
        check("t2_ce_high_in_stall", ce_hi_cnt, 0);
        check("t2_frozen_add", bus_a.rd_add, 3);
        check("t2_frozen_data", bus_a.rd_data, 3 ^ 8'hA5);
        check("t2_frozen_valid", bus_a.rd_valid, 1);
        bus_a.rd_ready = 1'b1;
        tick();
        check("t2_accept_valid", bus_a.rd_valid, 0);
        check("t2_accept_re", bus_a.re, 0);
        tick();
        check("t2_w4_valid", bus_a.rd_valid, 1);
        check("t2_w4_add", bus_a.rd_add, 4);
        check("t2_w4_data", bus_a.rd_data, 4 ^ 8'hA5);
        wait_done(1'b0, ncyc, nce, nlow, nfall);
        check("t2_done", bus_a.done, 1);
        tick();
        check("t2_words", q_add_a.size(), 32);
        errs = 0;
        for (int i = 0; i < q_add_a.size(); i++)
            if (q_add_a[i] != 5'(i) || q_dat_a[i] != (8'(i) ^ 8'hA5)) errs++;
        check("t2_order_errs", errs, 0);

        // T3: abort during the 10th RE_LO
        tick();
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b0);
        nlo = 0;
        for (int i = 0; i < 200 && nlo < 10; i++) begin
            tick();
            if (!bus_a.re) nlo++;
        end
        check("t3_reached_lo10", nlo, 10);
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("t3_hold_re", bus_a.re, 1);
        check("t3_hold_ce", bus_a.ce, 1);
        check("t3_hold_busy", bus_a.busy, 1);
        check("t3_hold_done", bus_a.done, 0);
        tick();
        check("t3_done", bus_a.done, 1);
        check("t3_busy_end", bus_a.busy, 0);
        tick();
        check("t3_words", q_add_a.size(), 9);
        if (q_add_a.size() > 0) check("t3_last_add", q_add_a[q_add_a.size()-1], 8);

        // T3b: abort in STALL leaves a pending word; start ignored until accepted
        tick();
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b0);
        wait_word_a(5'd2);
        bus_a.rd_ready = 1'b0;
        tick(); tick(); tick();
        bus_a.abort = 1'b1;
        tick();
        bus_a.abort = 1'b0;
        check("t3b_hold_ce", bus_a.ce, 1);
        tick();
        check("t3b_done", bus_a.done, 1);
        check("t3b_pending_valid", bus_a.rd_valid, 1);
        pulse_start(1'b0, 1'b0);
        check("t3b_start_ignored_busy", bus_a.busy, 0);
        check("t3b_start_ignored_ce", bus_a.ce, 1);
        check("t3b_pending_add", bus_a.rd_add, 2);
        bus_a.rd_ready = 1'b1;
        tick();
        check("t3b_delivered", bus_a.rd_valid, 0);
        check("t3b_words", q_add_a.size(), 3);

        // T4: asynchronous reset in the RE_LO after word 5
        tick();
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b0);
        wait_word_a(5'd5);
        tick();
        check("t4_pre_re_low", bus_a.re, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_ce", bus_a.ce, 1);
        check("t4_async_re", bus_a.re, 1);
        check("t4_async_valid", bus_a.rd_valid, 0);
        check("t4_async_busy", bus_a.busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        q_add_a.delete(); q_dat_a.delete();
        pulse_start(1'b0, 1'b0);
        wait_done(1'b0, ncyc, nce, nlow, nfall);
        check("t4_cycles", ncyc, 66);
        tick();
        check("t4_words", q_add_a.size(), 32);
        if (q_add_a.size() > 0) check("t4_first_add", q_add_a[0], 0);

        // T5: RE_HALF=3, BURST_LEN=4 on instance B
        q_add_b.delete(); q_dat_b.delete();
        pulse_start(1'b1, 1'b0);
        wait_done(1'b1, ncyc, nce, nlow, nfall);
        check("t5_cycles", ncyc, 26);
        check("t5_ce_low", nce, 25);
        check("t5_re_low", nlow, 12);
        check("t5_re_falls", nfall, 4);
        tick();
        check("t5_words", q_add_b.size(), 4);
        for (int i = 0; i < q_add_b.size(); i++) begin
            check($sformatf("t5_add%0d", i), q_add_b[i], i);
            check($sformatf("t5_data%0d", i), q_dat_b[i], i ^ 8'hA5);
        end

`ifdef RD_PARITY_EN
        // T6: wrong parity on word 7
        tick();
        par_bad = 1'b1;
        check("t6_err_init", bus_a.par_err, 0);
        pulse_start(1'b0, 1'b0);
        wait_word_a(5'd6);
        check("t6_err_before", bus_a.par_err, 0);
        wait_word_a(5'd7);
        check("t6_err_at_capture", bus_a.par_err, 1);
        wait_done(1'b0, ncyc, nce, nlow, nfall);
        check("t6_err_at_done", bus_a.par_err, 1);
        par_bad = 1'b0;
        bus_a.par_clr = 1'b1;
        tick();
        bus_a.par_clr = 1'b0;
        check("t6_err_cleared", bus_a.par_err, 0);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
`default_nettype wire
